fifo_read_port: RTL and testbench
=================================

// Module: fifo_read_port
// PURPOSE
// - Read-side controller for the 8-bit register-file FIFO.
// - Write side: binary address -> one-hot word enables.
// - This block works in the opposite direction. It keeps a one-hot read pointer and
//   encodes it 8->3 into a binary address. It selects the word at that address and
//   presents it on a registered valid/ready output.
// - Sits between the storage array/write controller and the downstream consumer.
// PARAMETERS
// - DATA_W  8  word width.
// - ADDR_W  3  address width; DEPTH = 1<<ADDR_W entries (8).
// PORTS
// - clk        in   1               rising-edge clock.
// - rst_n      in   1               asynchronous, active-low reset.
// - mem_flat   in   DEPTH*DATA_W    storage contents; word i = mem_flat[i*DATA_W +: DATA_W].
// - wr_ptr     in   ADDR_W+1        write pointer from the writer: {wrap, addr}.
// - flush      in   1               synchronous discard of all unread data.
// - out_data   out  DATA_W          registered read data.
// - out_valid  out  1               out_data is valid.
// - out_ready  in   1               consumer accepts out_data.
// - rd_ptr     out  ADDR_W+1        read pointer {wrap, addr}; the writer uses it for full.
// - rd_sel     out  DEPTH           one-hot read pointer (the next word to fetch).
// - empty      out  1               rd_ptr == wr_ptr (combinational).
// - level      out  ADDR_W+1        (wr_ptr - rd_ptr) mod 2^(ADDR_W+1); range 0..DEPTH.
// - onehot_err out  1               sticky: rd_sel was seen not one-hot.
// BEHAVIOUR
// - Reset, asynchronous while rst_n=0:
//   - rd_sel=8'b0000_0001, wrap=0, rd_ptr=0.
//   - out_valid=0, out_data=0, onehot_err=0.
// - Encoder: rd_ptr[ADDR_W-1:0] = index of the set bit in rd_sel.
//   - Purely combinational; priority to the lowest set bit if more than one bit is set.
//   - rd_sel == 0 encodes to 0.
// - Fetch condition: fetch = !empty && (!out_valid || out_ready) && !flush.
// - On fetch, at the clock edge:
//   - out_data <= word[rd_ptr addr]; out_valid <= 1.
//   - rd_sel rotates left by 1 (bit 7 -> bit 0).
//   - wrap toggles when rd_sel[DEPTH-1] was set.
// - out_ready && out_valid && !fetch -> out_valid <= 0; out_data holds its last value.
// - out_valid && !out_ready -> out_data and out_valid hold; no fetch.
// - Latency:
//   - wr_ptr advances at edge N -> out_valid=1 after edge N+1 (if the output register is free).
//   - Throughput: 1 word/cycle with out_ready held at 1.
// - Simultaneous accept and fetch in the same cycle: the new word replaces the old one;
//   out_valid stays 1, with no bubble.
// - Full (level==DEPTH): reads proceed normally. Fullness is the writer's job, computed
//   from rd_ptr.
// - Empty: no fetch; rd_sel is stable.
// - level counts words still in storage; it excludes a word already held in out_data.
// - flush=1 at an edge:
//   - rd_sel <= one-hot of wr_ptr addr; wrap <= wr_ptr wrap; out_valid <= 0.
//   - flush has priority over fetch and accept.
// - Integrity check: rd_sel not one-hot ($countones != 1) at an edge:
//   - onehot_err <= 1 (sticky until reset).
//   - rd_sel resyncs to the one-hot of the encoded index (or bit 0 if rd_sel == 0).
// - Reset mid-operation: all state returns to reset values immediately. The held word is
//   lost; the writer is reset alongside.
// TESTING
// - Reset state:
//   - Hold rst_n=0 and toggle clk.
//   - Expect rd_sel=0x01, rd_ptr=0, out_valid=0, empty=1 with wr_ptr=0, onehot_err=0.
// - Single word:
//   - mem word0=0xA5; wr_ptr 0->1 at edge N; out_ready=1.
//   - Expect out_data=0xA5, out_valid=1 after edge N+1; rd_ptr=1; out_valid=0 a cycle later.
// - Fill and wrap:
//   - words i=0x10+i; wr_ptr=8 (level=8); out_ready=1.
//   - Expect 0x10..0x17 on consecutive cycles; rd_ptr ends at 4'b1000; empty=1.
//   - Repeat with wr_ptr=0 to check the second wrap.
// - Backpressure:
//   - 3 words queued; out_ready=0 for 5 cycles.
//   - Expect out_data frozen on word0; rd_ptr=1; level=2.
//   - Then out_ready=1: words 1 and 2 follow back-to-back.
// - Flush:
//   - wr_ptr=5, rd_ptr=2, out_valid=1; pulse flush.
//   - Expect out_valid=0, rd_ptr=5, rd_sel=0x20, empty=1, level=0 after the edge.
// - Corruption and reset:
//   - Force rd_sel=0x24 for one cycle.
//   - Expect onehot_err=1 and rd_sel=0x04 after the edge.
//   - Assert rst_n mid-stream: expect all reset values asynchronously.

Source files
------------

// File: rtl/fifo_read_port.sv
// Read-side controller for the register-file FIFO.
// Keeps a one-hot read pointer plus a wrap bit, encodes the pointer to a
// binary address, fetches the addressed word into a registered valid/ready
// output stage, and reports empty/level to the rest of the FIFO.
module fifo_read_port #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DEPTH*DATA_W-1:0] mem_flat,
    input  logic [ADDR_W:0]         wr_ptr,
    input  logic                    flush,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_W:0]         rd_ptr,
    output logic [DEPTH-1:0]        rd_sel,
    output logic                    empty,
    output logic [ADDR_W:0]         level,
    output logic                    onehot_err
);

    localparam logic [DEPTH-1:0] SEL_ZERO = {{(DEPTH-1){1'b0}}, 1'b1};

    logic              rd_wrap;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_word;
    logic              sel_bad;
    logic              fetch;

    // Encode the one-hot pointer; scanning downward leaves the lowest set bit winning.
    always_comb begin
        rd_addr = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rd_sel[i]) begin
                rd_addr = ADDR_W'(i);
            end
        end
    end

    // Pointer arithmetic, word select and the fetch decision.
    always_comb begin
        rd_ptr  = {rd_wrap, rd_addr};
        empty   = (rd_ptr == wr_ptr);
        level   = wr_ptr - rd_ptr;
        rd_word = mem_flat[rd_addr*DATA_W +: DATA_W];
        // Zero bits set, or more than one bit set.
        sel_bad = (rd_sel == '0) || ((rd_sel & (rd_sel - SEL_ZERO)) != '0);
        // A corrupted pointer does not fetch: the word it names is ambiguous,
        // so the cycle is spent resynchronising instead.
        fetch   = !empty && (!out_valid || out_ready) && !flush && !sel_bad;
    end

    // Pointer, output register and integrity flag; flush beats resync beats fetch beats accept.
    // NOTE: sequential state is written with <= only, so every register samples
    // pre-edge values and block ordering cannot change the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel     <= SEL_ZERO;
            rd_wrap    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            onehot_err <= 1'b0;
        end else begin
            if (sel_bad) begin
                onehot_err <= 1'b1;
            end

            if (flush) begin
                rd_sel    <= SEL_ZERO << wr_ptr[ADDR_W-1:0];
                rd_wrap   <= wr_ptr[ADDR_W];
                out_valid <= 1'b0;
            end else if (sel_bad) begin
                rd_sel <= SEL_ZERO << rd_addr;
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end else if (fetch) begin
                out_data  <= rd_word;
                out_valid <= 1'b1;
                rd_sel    <= {rd_sel[DEPTH-2:0], rd_sel[DEPTH-1]};
                if (rd_sel[DEPTH-1]) begin
                    rd_wrap <= ~rd_wrap;
                end
            end else if (out_valid && out_ready) begin
                // Word accepted with nothing to replace it; out_data keeps its value.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_port.sv
// Directed testbench for fifo_read_port: reset, single word, fill/wrap twice,
// backpressure, flush, pointer corruption and asynchronous reset mid-stream.
module tb_fifo_read_port;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic                    clk;
    logic                    rst_n;
    logic [DEPTH*DATA_W-1:0] mem_flat;
    logic [ADDR_W:0]         wr_ptr;
    logic                    flush;
    logic [DATA_W-1:0]       out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [ADDR_W:0]         rd_ptr;
    logic [DEPTH-1:0]        rd_sel;
    logic                    empty;
    logic [ADDR_W:0]         level;
    logic                    onehot_err;

    int passed = 0;
    int total  = 0;

    fifo_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_flat   (mem_flat),
        .wr_ptr     (wr_ptr),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rd_ptr     (rd_ptr),
        .rd_sel     (rd_sel),
        .empty      (empty),
        .level      (level),
        .onehot_err (onehot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rd_sel"},     32'(rd_sel),     32'h01);
        check({tag, "_rd_ptr"},     32'(rd_ptr),     32'h0);
        check({tag, "_out_valid"},  32'(out_valid),  32'h0);
        check({tag, "_out_data"},   32'(out_data),   32'h0);
        check({tag, "_empty"},      32'(empty),      32'h1);
        check({tag, "_level"},      32'(level),      32'h0);
        check({tag, "_onehot_err"}, 32'(onehot_err), 32'h0);
    endtask

    task automatic load_words(input logic [7:0] base);
        for (int i = 0; i < DEPTH; i++) begin
            mem_flat[i*DATA_W +: DATA_W] = base + 8'(i);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        wr_ptr    = '0;
        mem_flat  = '0;

        // Reset held while the clock runs
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        // Single word: wr_ptr advances, word appears one edge later, then drains
        mem_flat[7:0] = 8'hA5;
        out_ready     = 1'b1;
        wr_ptr        = 4'd1;
        #1;
        check("single_level_before", 32'(level), 32'd1);
        check("single_empty_before", 32'(empty), 32'd0);
        @(negedge clk);
        check("single_data",  32'(out_data),  32'hA5);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_rd_ptr", 32'(rd_ptr),   32'd1);
        check("single_empty", 32'(empty),     32'd1);
        @(negedge clk);
        check("single_drained", 32'(out_valid), 32'd0);
        check("single_hold",    32'(out_data),  32'hA5);

        // Restart from pointer 0 (writer reset alongside)
        rst_n  = 1'b0;
        wr_ptr = '0;
        #1;
        rst_n = 1'b1;

        // Fill and wrap: eight words back to back
        load_words(8'h10);
        wr_ptr = 4'd8;
        #1;
        check("fill_level", 32'(level), 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check($sformatf("fill_data%0d", i), 32'(out_data), 32'h10 + 32'(i));
            check($sformatf("fill_valid%0d", i), 32'(out_valid), 32'd1);
        end
        check("fill_rd_ptr", 32'(rd_ptr), 32'b1000);
        check("fill_rd_sel", 32'(rd_sel), 32'h01);
        check("fill_empty",  32'(empty),  32'd1);

        // Second wrap: wr_ptr back to 0 is again eight words ahead
        load_words(8'h20);
        wr_ptr = 4'd0;
        #1;
        check("wrap2_level", 32'(level), 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check($sformatf("wrap2_data%0d", i), 32'(out_data), 32'h20 + 32'(i));
        end
        check("wrap2_rd_ptr", 32'(rd_ptr), 32'd0);
        check("wrap2_empty",  32'(empty),  32'd1);
        @(negedge clk);
        check("wrap2_drained", 32'(out_valid), 32'd0);

        // Backpressure: three words queued, consumer stalls five cycles
        load_words(8'h30);
        out_ready = 1'b0;
        wr_ptr    = 4'd3;
        @(negedge clk);
        check("bp_first", 32'(out_data), 32'h30);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_frozen%0d", i), 32'(out_data), 32'h30);
        end
        check("bp_valid",  32'(out_valid), 32'd1);
        check("bp_rd_ptr", 32'(rd_ptr),    32'd1);
        check("bp_level",  32'(level),     32'd2);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_word1", 32'(out_data), 32'h31);
        @(negedge clk);
        check("bp_word2",  32'(out_data),  32'h32);
        check("bp_valid2", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_rd_ptr3", 32'(rd_ptr),    32'd3);

        // Flush: reach rd_ptr=2 with a word held, wr_ptr=5, then flush
        rst_n  = 1'b0;
        wr_ptr = '0;
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b0;
        wr_ptr    = 4'd5;
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        check("flush_pre_rd_ptr", 32'(rd_ptr),    32'd2);
        check("flush_pre_valid",  32'(out_valid), 32'd1);
        check("flush_pre_data",   32'(out_data),  32'h31);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_valid",  32'(out_valid), 32'd0);
        check("flush_rd_ptr", 32'(rd_ptr),    32'd5);
        check("flush_rd_sel", 32'(rd_sel),    32'h20);
        check("flush_empty",  32'(empty),     32'd1);
        check("flush_level",  32'(level),     32'd0);

        // Corruption: two bits set in the pointer for one edge
        @(negedge clk);
        wr_ptr = 4'd2;
        force dut.rd_sel = 8'h24;
        @(posedge clk);
        #1;
        release dut.rd_sel;
        check("corrupt_err", 32'(onehot_err), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("corrupt_rd_sel", 32'(rd_sel),     32'h04);
        check("corrupt_rd_ptr", 32'(rd_ptr),     32'd2);
        check("corrupt_empty",  32'(empty),      32'd1);
        check("corrupt_sticky", 32'(onehot_err), 32'd1);
        check("corrupt_valid",  32'(out_valid),  32'd0);

        // Reset mid-stream: start a stream, then drop rst_n between edges
        out_ready = 1'b1;
        wr_ptr    = 4'd6;
        @(negedge clk);
        check("stream_word2", 32'(out_data), 32'h32);
        @(negedge clk);
        check("stream_word3", 32'(out_data), 32'h33);
        #2;
        rst_n  = 1'b0;
        wr_ptr = '0;
        #1;
        check_reset_state("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_rd_sel", 32'(rd_sel),    32'h01);
        check("post_reset_valid",  32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
